// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } mon_state_e;

    // Width of a counter that must hold values up to 2*ratio.
    function automatic int cnt_width(input int ratio);
        return $clog2(2 * ratio + 1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input with registered
// one-cycle rise/fall pulses. A transition sampled at edge k produces a
// pulse in the cycle that follows edge k+STAGES.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev;

    // Synchronizer chain, delayed copy of the last stage and registered edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev   <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev   <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~prev;
            fall   <= ~sync_q[STAGES-1] & prev;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clk_div_monitor.sv
// Fast-domain checker for an even-divided clock: measures period and high
// time, flags ratio/duty errors and timeouts, and declares lock after
// LOCK_CNT consecutive good periods.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter  int EXP_RATIO   = 8,
    parameter  int LOCK_CNT    = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int CW          = cnt_width(EXP_RATIO)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          clk_div_in,
    output logic          rise_pulse,
    output logic          fall_pulse,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic          locked,
    output logic          err,
    output logic [7:0]    err_cnt
);

    localparam int            MW      = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(2 * EXP_RATIO);
    localparam logic [CW-1:0] CNT_TO  = CW'(2 * EXP_RATIO - 1);
    localparam logic [CW-1:0] EXP_P   = CW'(EXP_RATIO);
    localparam logic [CW-1:0] EXP_H   = CW'(EXP_RATIO / 2);
    localparam logic [MW-1:0] LOCK_M  = MW'(LOCK_CNT);

    logic          div_level_unused;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          seen_rise;
    logic          fall_seen;
    logic [MW-1:0] match;
    logic [MW-1:0] match_inc;
    logic          good;
    logic          timeout;
    logic          bad_rise;
    logic          err_evt;
    mon_state_e    state;

    // The level output is not needed here; the pulses carry everything.
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (clk_div_in),
        .q    (div_level_unused),
        .rise (rise_pulse),
        .fall (fall_pulse)
    );

    assign cnt_inc   = cnt + 1'b1;
    assign match_inc = match + 1'b1;
    assign locked    = (state == LOCKED);

    // Classify the current cycle: good/bad period on a rise, or a timeout
    always_comb begin
        good     = (cnt_inc == EXP_P) && fall_seen && (high_time == EXP_H);
        timeout  = (state != IDLE) && !rise_pulse && (cnt == CNT_TO);
        bad_rise = rise_pulse && (state != IDLE) && !good;
        err_evt  = timeout || bad_rise;
    end

    // Cycle counter: restarts on each rise, saturates at twice the expected ratio
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || rise_pulse) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt_inc;
        end
    end

    // Period/high-time capture; only meaningful once a reference rise exists
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_rise <= 1'b0;
            fall_seen <= 1'b0;
            period    <= '0;
            high_time <= '0;
        end else if (clear) begin
            seen_rise <= 1'b0;
            fall_seen <= 1'b0;
            period    <= '0;
            high_time <= '0;
        end else begin
            if (rise_pulse) begin
                seen_rise <= 1'b1;
                fall_seen <= 1'b0;
                if (seen_rise) period <= cnt_inc;
            end
            if (fall_pulse) begin
                fall_seen <= 1'b1;
                if (seen_rise) high_time <= cnt_inc;
            end
        end
    end

    // Lock FSM with consecutive-good-period counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            match <= '0;
        end else if (clear) begin
            state <= IDLE;
            match <= '0;
        end else if (timeout) begin
            state <= IDLE;
            match <= '0;
        end else if (rise_pulse) begin
            case (state)
                IDLE: begin
                    state <= MEASURE;
                    match <= '0;
                end
                MEASURE: begin
                    if (good) begin
                        state <= (LOCK_M == MW'(1)) ? LOCKED : TRACK;
                        match <= MW'(1);
                    end
                end
                TRACK: begin
                    if (good) begin
                        match <= match_inc;
                        if (match_inc == LOCK_M) state <= LOCKED;
                    end else begin
                        state <= MEASURE;
                        match <= '0;
                    end
                end
                default: begin
                    if (!good) begin
                        state <= MEASURE;
                        match <= '0;
                    end
                end
            endcase
        end
    end

    // Error pulse and saturating error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (clear) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= err_evt;
            if (err_evt && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
